fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's 8-bit synchronous FIFO.
- Drives the FIFO read enable and captures read data, which arrives one cycle after the read is issued.
- Re-presents the captured data as a valid/ready stream to downstream logic, buffering internally so that no byte is lost or duplicated under backpressure.
- Sits between the FIFO and a byte consumer such as a UART transmitter or packet builder.

Parameters:
DATA_W, 8, width of a FIFO word and of the stream data.
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
enable  input  1  1 = allowed to issue new FIFO reads.
fifo_empty  input  1  FIFO empty flag.
fifo_rdata  input  DATA_W  FIFO read data; valid the cycle after a read is issued.
fifo_rd_en  output  1  FIFO read enable.
m_valid  output  1  stream data valid.
m_data  output  DATA_W  stream data.
m_ready  input  1  downstream accepts m_data.
rd_count  output  CNT_W  number of words delivered on the stream; wraps.
busy  output  1  a read is in flight or buffered data remains.

Behaviour:
- Internal state:
  - 3-entry in-order buffer with occupancy occ in 0..3.
  - 1-bit inflight register, equal to fifo_rd_en registered.
- Read issue (combinational):
  - fifo_rd_en = reset & enable & !fifo_empty & (occ + inflight < 3).
  - There is no combinational path from m_ready to fifo_rd_en.
- Capture: on each clock edge where inflight = 1, fifo_rdata is written to the buffer tail.
- Pop: on each clock edge where m_valid & m_ready, the head is removed.
- Simultaneous push and pop: both occur in the same edge, occ is unchanged, and order is preserved.
- Stream outputs:
  - m_valid = (occ != 0).
  - m_data = buffer head, held stable while m_valid & !m_ready.
  - When occ = 0, m_data holds its last value.
- Latency:
  - fifo_rd_en high at edge k → data on fifo_rdata after edge k → captured at edge k+1 → m_valid high after edge k+1.
  - First word therefore appears 2 cycles after fifo_empty falls.
- Throughput: with m_ready held at 1 and the FIFO non-empty, one word per cycle is sustained indefinitely (occ = 1, inflight = 1 steady state).
- Backpressure: with m_ready = 0, at most 3 reads are issued in total (buffer plus in-flight), then fifo_rd_en stays 0 until a pop occurs.
- Empty boundary:
  - fifo_rd_en is never asserted while fifo_empty = 1.
  - Buffered words still drain; m_valid falls when occ reaches 0.
- Enable low:
  - No new reads are issued.
  - An in-flight word is still captured, and buffered words are still delivered.
- rd_count: increments by 1 on every m_valid & m_ready; wraps from 2^CNT_W-1 to 0.
- busy = (occ != 0) | inflight.
- Reset (asynchronous, active-low):
  - occ = 0, inflight = 0, m_valid = 0, m_data = 0, rd_count = 0, busy = 0, fifo_rd_en = 0.
  - Any in-flight word at reset assertion is discarded.
  - After reset deasserts, operation restarts from the empty state, with no spurious capture of fifo_rdata.

Test Plan:
1. Streaming: FIFO preloaded with 0x11,0x22,...,0x88; enable=1; m_ready=1 → m_data 0x11..0x88 on consecutive cycles, first word 2 cycles after the first fifo_rd_en; rd_count=8; busy=0 at the end.
2. Backpressure: same preload with m_ready=0 → exactly 3 fifo_rd_en pulses; m_valid=1 with m_data=0x11 held. Release m_ready → 0x11..0x88 delivered in order with no gaps, losses or duplicates.
3. Empty boundary: FIFO holds 2 words → 2 reads issued, fifo_rd_en stays 0 while fifo_empty=1, m_valid falls after the second word. Write 0x5A later → delivered 2 cycles after fifo_empty falls.
4. Enable drop: deassert enable in the cycle fifo_rd_en issues the read for 0x33 → 0x33 is still captured and delivered; no further fifo_rd_en until enable=1.
5. Reset mid-operation: drive reset low with occ=2 and inflight=1 → all outputs go to 0 immediately, before the next edge. After release, 0x99 written to the FIFO → delivered as the first word, rd_count=1.
6. Counter wrap: force rd_count to 0xFFFF via 65535 handshakes (or a shortened CNT_W=4 run), then one more handshake → rd_count=0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for an 8-bit synchronous FIFO: issues reads, captures the
// one-cycle-late read data and re-presents it as a valid/ready byte stream.
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic              busy
);

    logic [1:0]        r_occ;
    logic              r_inflight;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] w_entry [3];
    logic [2:0]        w_pending;
    logic              w_pop;
    logic              w_push;
    logic [1:0]        w_wr_idx;

    // A read is only issued if a buffer slot is guaranteed for its data.
    assign w_pending  = {1'b0, r_occ} + {2'b00, r_inflight};
    assign fifo_rd_en = reset & enable & ~fifo_empty & (w_pending < 3'd3);

    assign m_valid  = (r_occ != 2'd0);
    assign m_data   = w_entry[0];
    assign w_pop    = m_valid & m_ready;
    assign w_push   = r_inflight;
    assign w_wr_idx = r_occ - {1'b0, w_pop};
    assign busy     = m_valid | r_inflight;
    assign rd_count = r_count;

    // Entry 0 is always the head; a pop shifts the valid entries down by one,
    // and a word arriving in the same cycle lands just behind the survivors.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_entry
            logic [DATA_W-1:0] r_data;
            logic [DATA_W-1:0] w_shift_in;

            if (gi < 2) begin : g_shift
                assign w_shift_in = w_entry[gi+1];
            end else begin : g_last
                assign w_shift_in = r_data;
            end

            assign w_entry[gi] = r_data;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_data <= '0;
                end else if (w_push && (w_wr_idx == 2'(gi))) begin
                    r_data <= fifo_rdata;
                end else if (w_pop && ({1'b0, r_occ} > 3'(gi + 1))) begin
                    r_data <= w_shift_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_count    <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            r_occ      <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule
